// File: rtl/apb_slave_pkg.sv
// Shared types and defaults for the APB memory completer.
// Holds the FSM state encoding, default geometry and the wait-counter width.
package apb_slave_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 256;
    localparam int WAIT_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apb_state_t;

    // Index width for a memory of the given depth; never narrower than one bit.
    function automatic int mem_addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word-wide register-file memory: synchronous write, combinational read,
// synchronous whole-array clear.
module apb_mem_array
    import apb_slave_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MEM_DEPTH  = DEF_MEM_DEPTH,
    localparam int AW         = mem_addr_bits(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // NOTE: the array is cleared word by word so that reset yields a known
    // all-zero memory; this costs a reset path on every storage bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB (AMBA 3) completer in front of a word-addressed memory, with a
// compile-time number of wait states before pready rises.
module apb_mem_slave
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready
);

    localparam int MEM_AW = mem_addr_bits(MEM_DEPTH);

    apb_state_t             state, state_next;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_next;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_next;
    logic                   write_q, write_next;
    logic [DATA_WIDTH-1:0]  prdata_q;
    logic                   pready_q;
    logic                   mem_we;
    logic                   load_rd;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 64'(a) < 64'(MEM_DEPTH);
    endfunction

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        addr_next  = addr_q;
        write_next = write_q;
        mem_we     = 1'b0;
        load_rd    = 1'b0;

        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    addr_next  = paddr;
                    write_next = pwrite;
                    if (WAIT_STATES == 0) begin
                        state_next = READY;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (cnt_q == '0) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            READY: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (penable) begin
                    state_next = IDLE;
                    mem_we     = write_q && in_range(addr_q);
                end
            end
            default: state_next = IDLE;
        endcase

        // Read data is captured on the edge that enters READY, so the
        // address may be the one being latched on that same edge.
        load_rd = (state_next == READY) && (state != READY) && !write_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else begin
            state    <= state_next;
            cnt_q    <= cnt_next;
            addr_q   <= addr_next;
            write_q  <= write_next;
            pready_q <= (state_next == READY);
            if (load_rd) begin
                prdata_q <= in_range(addr_next) ? mem_rdata : '0;
            end
        end
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .clr   (!rst_n),
        .we    (mem_we && rst_n),
        .waddr (addr_q[MEM_AW-1:0]),
        .wdata (pwdata),
        .raddr (addr_next[MEM_AW-1:0]),
        .rdata (mem_rdata)
    );

    assign prdata = prdata_q;
    assign pready = pready_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one instance with no wait states and one
// with three, each on its own APB bus, sharing clock and reset.
module tb_apb_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  paddr0, paddr3;
    logic        pwrite0, pwrite3;
    logic        psel0, psel3;
    logic        penable0, penable3;
    logic [31:0] pwdata0, pwdata3;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr0), .pwrite(pwrite0), .psel(psel0),
        .penable(penable0), .pwdata(pwdata0), .prdata(prdata0), .pready(pready0)
    );

    apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr3), .pwrite(pwrite3), .psel(psel3),
        .penable(penable3), .pwdata(pwdata3), .prdata(prdata3), .pready(pready3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s3, input logic sel, input logic en, input logic wr,
                         input logic [7:0] a, input logic [31:0] d);
        if (s3) begin
            psel3 = sel; penable3 = en; pwrite3 = wr; paddr3 = a; pwdata3 = d;
        end else begin
            psel0 = sel; penable0 = en; pwrite0 = wr; paddr0 = a; pwdata0 = d;
        end
    endtask

    function automatic logic rdy(input bit s3);
        return s3 ? pready3 : pready0;
    endfunction

    // One transfer; returns once pready is seen, leaving the completion edge
    // to the next call so transfers run back-to-back.
    task automatic xfer(input bit s3, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int cyc);
        @(posedge clk); #1;
        drive(s3, 1'b1, 1'b0, wr, a, d);
        cyc = 1;
        @(posedge clk); #1;
        drive(s3, 1'b1, 1'b1, wr, a, d);
        cyc = 2;
        while (!rdy(s3) && cyc < 32) begin
            @(posedge clk); #1;
            cyc++;
        end
        rd = s3 ? prdata3 : prdata0;
    endtask

    task automatic idle(input bit s3);
        @(posedge clk); #1;
        drive(s3, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          total;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

        // Reset state
        @(posedge clk); #1;
        check("reset_pready0", {31'b0, pready0}, 32'd0);
        check("reset_prdata0", prdata0, 32'h0);
        check("reset_pready3", {31'b0, pready3}, 32'd0);
        rst_n = 1'b1;

        xfer(1'b0, 1'b0, 8'h10, 32'h0, rd, cyc);
        check("rd_0x10_after_reset", rd, 32'h0);
        check("rd_0x10_cycles", 32'(cyc), 32'd2);

        // Zero-wait write/read and prdata hold across a write
        xfer(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, rd, cyc);
        check("wr_0x05_cycles", 32'(cyc), 32'd2);
        xfer(1'b0, 1'b0, 8'h05, 32'h0, rd, cyc);
        check("rd_0x05", rd, 32'hDEADBEEF);
        check("rd_0x05_cycles", 32'(cyc), 32'd2);
        xfer(1'b0, 1'b1, 8'h06, 32'hCAFEF00D, rd, cyc);
        idle(1'b0);
        check("prdata_hold_after_write", prdata0, 32'hDEADBEEF);
        check("pready0_idle", {31'b0, pready0}, 32'd0);

        // Back-to-back sweep
        total = 0;
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 1'b1, 8'(i), 32'(i * 3), rd, cyc);
            total += cyc;
        end
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 1'b0, 8'(i), 32'h0, rd, cyc);
            total += cyc;
            check($sformatf("sweep_rd_%0d", i), rd, 32'(i * 3));
        end
        check("sweep_total_cycles", 32'(total), 32'd1024);
        idle(1'b0);

        // Three wait states
        xfer(1'b1, 1'b1, 8'hFF, 32'h12345678, rd, cyc);
        check("ws3_wr_cycles", 32'(cyc), 32'd5);
        xfer(1'b1, 1'b0, 8'hFF, 32'h0, rd, cyc);
        check("ws3_rd_0xff", rd, 32'h12345678);
        check("ws3_rd_cycles", 32'(cyc), 32'd5);
        idle(1'b1);

        // Abort during WAIT
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 32'hA5A5A5A5);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 32'hA5A5A5A5);
        check("abort_ws3_pready_wait", {31'b0, pready3}, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(posedge clk); #1;
        check("abort_ws3_pready_idle", {31'b0, pready3}, 32'd0);
        xfer(1'b1, 1'b0, 8'h20, 32'h0, rd, cyc);
        check("abort_ws3_rd_0x20", rd, 32'h0);
        check("abort_ws3_rd_cycles", 32'(cyc), 32'd5);
        idle(1'b1);

        // Abort while READY (zero wait states): 0x20 keeps its sweep value
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 32'hA5A5A5A5);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 32'hA5A5A5A5);
        xfer(1'b0, 1'b0, 8'h20, 32'h0, rd, cyc);
        check("abort_ws0_rd_0x20", rd, 32'h60);
        idle(1'b0);

        // Reset in the middle of a wait-state transfer
        xfer(1'b1, 1'b1, 8'h01, 32'h00000011, rd, cyc);
        xfer(1'b1, 1'b0, 8'h01, 32'h0, rd, cyc);
        check("pre_reset_rd_0x01", rd, 32'h00000011);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 32'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_pready3", {31'b0, pready3}, 32'd0);
        check("midreset_prdata3", prdata3, 32'h0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        xfer(1'b1, 1'b0, 8'h01, 32'h0, rd, cyc);
        check("post_reset_rd_0x01", rd, 32'h0);
        check("post_reset_rd_cycles", 32'(cyc), 32'd5);
        idle(1'b1);
        xfer(1'b0, 1'b0, 8'h05, 32'h0, rd, cyc);
        check("post_reset_ws0_rd_0x05", rd, 32'h0);
        idle(1'b0);

        // penable without a setup phase
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 32'hBAD0BAD0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("strobe_pready_%0d", k), {31'b0, pready0}, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        xfer(1'b0, 1'b0, 8'h07, 32'h0, rd, cyc);
        check("strobe_rd_0x07", rd, 32'h0);
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
